// File: rtl/day10_machine_solver.sv
// day10_machine_solver
//   Solves one Day 10 machine per transaction. It finds a minimum-size set of
//   buttons whose XORed light masks equal the target light pattern. Candidate
//   subsets are visited in Gray-code order, one per cycle, so each step
//   toggles exactly one button in the running XOR accumulator.
//
// Handshakes (both sides): a transfer happens on a rising clk edge where
//   valid && ready. in_ready is high only in IDLE. out_valid and all result
//   fields hold steady from the rise of out_valid until the edge where
//   out_ready is seen high.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   machine descriptor handshake
//   target_lights       required light pattern (bit i = light i)
//   num_buttons         buttons in use (clamped to MAX_NUM_BUTTONS)
//   button_masks        button b at [b*MAX_NUM_LIGHTS +: MAX_NUM_LIGHTS]
//   out_valid/out_ready result handshake
//   solvable            some subset matches the target
//   min_button_presses  popcount of the best subset (0 when unsolvable)
//   buttons_to_press    best subset, bit b = press button b (0 when unsolvable)
module day10_machine_solver #(
    parameter int MAX_NUM_LIGHTS    = 16,
    parameter int MAX_NUM_BUTTONS   = 13,
    parameter int MAX_NUM_BUTTONS_W = (MAX_NUM_BUTTONS <= 1 ? 1 : $clog2(MAX_NUM_BUTTONS + 1)),
    parameter int MAX_NUM_PRESSES_W = MAX_NUM_BUTTONS_W
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic                                      in_valid,
    output logic                                      in_ready,
    input  logic [MAX_NUM_LIGHTS-1:0]                 target_lights,
    input  logic [MAX_NUM_BUTTONS_W-1:0]              num_buttons,
    input  logic [MAX_NUM_BUTTONS*MAX_NUM_LIGHTS-1:0] button_masks,
    output logic                                      out_valid,
    input  logic                                      out_ready,
    output logic                                      solvable,
    output logic [MAX_NUM_PRESSES_W-1:0]              min_button_presses,
    output logic [MAX_NUM_BUTTONS-1:0]                buttons_to_press
);

    localparam int L     = MAX_NUM_LIGHTS;
    localparam int B     = MAX_NUM_BUTTONS;
    localparam int KW    = MAX_NUM_BUTTONS + 1;  // one spare bit so 2^B-1 never wraps
    localparam int IDX_W = (MAX_NUM_BUTTONS <= 1) ? 1 : $clog2(MAX_NUM_BUTTONS);
    localparam int PW    = MAX_NUM_PRESSES_W;

    typedef enum logic [1:0] {IDLE = 2'd0, SEARCH = 2'd1, DONE = 2'd2} state_t;
    state_t state, state_next;

    // Captured descriptor
    logic [L-1:0]                 target_q;
    logic [L-1:0]                 masks_q [B];
    logic [MAX_NUM_BUTTONS_W-1:0] n_q;

    // Search state
    logic [L-1:0]  acc;
    logic [B-1:0]  subset;
    logic [PW-1:0] cnt;
    logic [KW-1:0] k;
    logic          found;
    logic [B-1:0]  best_subset;
    logic [PW-1:0] best_cnt;

    // Search step helpers
    logic [KW-1:0]    k_next;
    logic [KW-1:0]    last_k;
    logic             last;
    logic             match;
    logic [IDX_W-1:0] t;
    logic [MAX_NUM_BUTTONS_W-1:0] n_clamped;

    assign n_clamped = (num_buttons > MAX_NUM_BUTTONS_W'(B)) ? MAX_NUM_BUTTONS_W'(B) : num_buttons;
    assign k_next    = k + KW'(1);
    assign last_k    = (KW'(1) << n_q) - KW'(1);
    assign last      = (k == last_k);
    assign match     = (acc == target_q);

    // Index of the lowest set bit of k_next: the button that flips between
    // Gray codes k and k+1. Only consulted when k < 2^n-1, so t < n.
    always_comb begin
        t = '0;
        for (int i = B - 1; i >= 0; i--) begin
            if (k_next[i]) t = IDX_W'(i);
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid)               state_next = SEARCH;
            SEARCH:  if (last)                   state_next = DONE;
            DONE:    if (out_valid && out_ready) state_next = IDLE;
            default:                             state_next = IDLE;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        in_ready = (state == IDLE);
    end

    // Datapath and registered result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            target_q           <= '0;
            n_q                <= '0;
            acc                <= '0;
            subset             <= '0;
            cnt                <= '0;
            k                  <= '0;
            found              <= 1'b0;
            best_subset        <= '0;
            best_cnt           <= '0;
            out_valid          <= 1'b0;
            solvable           <= 1'b0;
            min_button_presses <= '0;
            buttons_to_press   <= '0;
            for (int b = 0; b < B; b++) masks_q[b] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        target_q <= target_lights;
                        n_q      <= n_clamped;
                        for (int b = 0; b < B; b++) masks_q[b] <= button_masks[b*L +: L];
                        acc      <= '0;
                        subset   <= '0;
                        cnt      <= '0;
                        k        <= '0;
                        found    <= 1'b0;
                    end
                end
                SEARCH: begin
                    // Strictly smaller count only: ties keep the earliest Gray match
                    if (match && (!found || cnt < best_cnt)) begin
                        best_subset <= subset;
                        best_cnt    <= cnt;
                        found       <= 1'b1;
                    end
                    if (!last) begin
                        k      <= k_next;
                        acc    <= acc ^ masks_q[t];
                        subset <= subset ^ (B'(1) << t);
                        cnt    <= subset[t] ? cnt - PW'(1) : cnt + PW'(1);
                    end
                end
                DONE: begin
                    // First DONE cycle latches the result; it then holds until taken
                    if (!out_valid) begin
                        out_valid          <= 1'b1;
                        solvable           <= found;
                        min_button_presses <= found ? best_cnt : '0;
                        buttons_to_press   <= found ? best_subset : '0;
                    end else if (out_ready) begin
                        out_valid          <= 1'b0;
                        solvable           <= 1'b0;
                        min_button_presses <= '0;
                        buttons_to_press   <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
